// File: rtl/hdmi_intf.sv
// 640x480@60 DVI/HDMI source: raster timing, 8-bar colour pattern and TMDS
// encoding of three colour channels into parallel 10-bit symbols for a 10:1 serializer.
module hdmi_intf #(
    parameter int HORIZONTAL_PIXELS = 800,
    parameter int VERTICAL_LINES    = 525,
    parameter int H_ACTIVE          = 640,
    parameter int H_FRONT           = 16,
    parameter int H_SYNC            = 96,
    parameter int V_ACTIVE          = 480,
    parameter int V_FRONT           = 10,
    parameter int V_SYNC            = 2,
    parameter int SYNC_ACTIVE_LOW   = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic [9:0] tmds_clk
);
    localparam logic [9:0] H_LAST_C   = 10'(HORIZONTAL_PIXELS - 1);
    localparam logic [9:0] V_LAST_C   = 10'(VERTICAL_LINES - 1);
    localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG_C   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG_C   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic       SYNC_ON_C  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [9:0] CTRL_00_C  = 10'b1101010100;
    localparam logic [9:0] CTRL_01_C  = 10'b0010101011;
    localparam logic [9:0] CTRL_10_C  = 10'b0101010100;
    localparam logic [9:0] CTRL_11_C  = 10'b1010101011;
    localparam logic [9:0] TMDS_CLK_C = 10'b0000011111;

    logic [9:0]        h_cnt_r, v_cnt_r;
    logic              de_s, hs_on_s, vs_on_s;
    logic [2:0]        bar_s;
    logic [23:0]       colour_s, rgb_s;
    logic              de_r, hsync_r, vsync_r;
    logic [23:0]       rgb_r;
    logic [15:0]       enc0_s, enc1_s, enc2_s;
    logic [9:0]        ch0_r, ch1_r, ch2_r;
    logic signed [5:0] disp0_r, disp1_r, disp2_r;

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic c1, input logic c0);
        logic [9:0] s;
        case ({c1, c0})
            2'b00:   s = CTRL_00_C;
            2'b01:   s = CTRL_01_C;
            2'b10:   s = CTRL_10_C;
            2'b11:   s = CTRL_11_C;
            default: s = CTRL_00_C;
        endcase
        return s;
    endfunction

    // Returns {next running disparity, 10-bit symbol}; bal is ones minus zeros of q_m[7:0].
    function automatic logic [15:0] tmds_encode(input logic [7:0] d, input logic signed [5:0] cnt);
        logic [8:0]        qm;
        logic [3:0]        n1d, n1q;
        logic signed [5:0] bal, nxt;
        logic [9:0]        q;
        logic              use_xnor;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                qm[i] = ~(qm[i-1] ^ d[i]);
            end else begin
                qm[i] = qm[i-1] ^ d[i];
            end
        end
        qm[8] = ~use_xnor;
        n1q   = ones8(qm[7:0]);
        bal   = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        if ((cnt == 6'sd0) || (n1q == 4'd4)) begin
            q   = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nxt = qm[8] ? (cnt + bal) : (cnt - bal);
        end else if (((cnt > 6'sd0) && (bal > 6'sd0)) || ((cnt < 6'sd0) && (bal < 6'sd0))) begin
            q   = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + (qm[8] ? 6'sd2 : 6'sd0) - bal;
        end else begin
            q   = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - (qm[8] ? 6'sd0 : 6'sd2) + bal;
        end
        return {nxt, q};
    endfunction

    // Raster counters: h wraps every line, v advances on h wrap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_r <= 10'd0;
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
        end
    end

    // Timing decode and colour-bar selection from the current counters.
    always_comb begin
        de_s    = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_on_s = (h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C);
        vs_on_s = (v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C);
        if (h_cnt_r < 10'd80) begin
            bar_s = 3'd0;
        end else if (h_cnt_r < 10'd160) begin
            bar_s = 3'd1;
        end else if (h_cnt_r < 10'd240) begin
            bar_s = 3'd2;
        end else if (h_cnt_r < 10'd320) begin
            bar_s = 3'd3;
        end else if (h_cnt_r < 10'd400) begin
            bar_s = 3'd4;
        end else if (h_cnt_r < 10'd480) begin
            bar_s = 3'd5;
        end else if (h_cnt_r < 10'd560) begin
            bar_s = 3'd6;
        end else begin
            bar_s = 3'd7;
        end
        case (bar_s)
            3'd0:    colour_s = 24'hFFFFFF;
            3'd1:    colour_s = 24'hFFFF00;
            3'd2:    colour_s = 24'h00FFFF;
            3'd3:    colour_s = 24'h00FF00;
            3'd4:    colour_s = 24'hFF00FF;
            3'd5:    colour_s = 24'hFF0000;
            3'd6:    colour_s = 24'h0000FF;
            default: colour_s = 24'h000000;
        endcase
        if (de_s) begin
            rgb_s = colour_s;
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Stage 1: registered timing strobes and pixel colour.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            de_r    <= 1'b0;
            hsync_r <= ~SYNC_ON_C;
            vsync_r <= ~SYNC_ON_C;
            rgb_r   <= 24'h000000;
        end else begin
            de_r    <= de_s;
            hsync_r <= hs_on_s ? SYNC_ON_C : ~SYNC_ON_C;
            vsync_r <= vs_on_s ? SYNC_ON_C : ~SYNC_ON_C;
            rgb_r   <= rgb_s;
        end
    end

    // Per-channel encoder results against each channel's running disparity.
    always_comb begin
        enc0_s = tmds_encode(rgb_r[7:0], disp0_r);
        enc1_s = tmds_encode(rgb_r[15:8], disp1_r);
        enc2_s = tmds_encode(rgb_r[23:16], disp2_r);
    end

    // Stage 2: TMDS symbols; blanking sends control codes and clears disparity.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ch0_r   <= ctrl_symbol(~SYNC_ON_C, ~SYNC_ON_C);
            ch1_r   <= CTRL_00_C;
            ch2_r   <= CTRL_00_C;
            disp0_r <= 6'sd0;
            disp1_r <= 6'sd0;
            disp2_r <= 6'sd0;
        end else if (de_r) begin
            ch0_r   <= enc0_s[9:0];
            ch1_r   <= enc1_s[9:0];
            ch2_r   <= enc2_s[9:0];
            disp0_r <= enc0_s[15:10];
            disp1_r <= enc1_s[15:10];
            disp2_r <= enc2_s[15:10];
        end else begin
            ch0_r   <= ctrl_symbol(vsync_r, hsync_r);
            ch1_r   <= ctrl_symbol(1'b0, 1'b0);
            ch2_r   <= ctrl_symbol(1'b0, 1'b0);
            disp0_r <= 6'sd0;
            disp1_r <= 6'sd0;
            disp2_r <= 6'sd0;
        end
    end

    assign pixel_x  = h_cnt_r;
    assign pixel_y  = v_cnt_r;
    assign de       = de_r;
    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign tmds_ch0 = ch0_r;
    assign tmds_ch1 = ch1_r;
    assign tmds_ch2 = ch2_r;
    assign tmds_clk = TMDS_CLK_C;
endmodule

// File: tb/tb_hdmi_intf.sv
// Self-checking bench for hdmi_intf. Horizontal timing is full 800-clock lines;
// the frame is shortened vertically (20 lines) so whole frames run quickly.
module tb_hdmi_intf;
    localparam int HP = 800, VL = 20, HA = 640, HF = 16, HS = 96;
    localparam int VA = 12, VF = 3, VS = 2;
    localparam int FRAME = HP * VL;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       hsync, vsync, de;
    logic [9:0] pixel_x, pixel_y, tmds_ch0, tmds_ch1, tmds_ch2, tmds_clk;

    hdmi_intf #(
        .HORIZONTAL_PIXELS(HP), .VERTICAL_LINES(VL), .H_ACTIVE(HA), .H_FRONT(HF),
        .H_SYNC(HS), .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hsync(hsync), .vsync(vsync), .de(de),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1),
        .tmds_ch2(tmds_ch2), .tmds_clk(tmds_clk)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int failed = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [9:0]  ctrl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference state: what the DUT should show at the current sample point.
    int          k;
    logic        e_de, e_hs, e_vs;
    logic [23:0] e_rgb;
    logic [9:0]  e_sym [3];
    int          e_cnt [3];

    function automatic int ones_of(input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d, o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    task automatic ref_encode(input logic [7:0] d, input int cnt_in, output logic [9:0] sym, output int cnt_out);
        logic [8:0] qm;
        int n1d, ones, zeros;
        bit use_xnor;
        n1d = ones_of({2'b00, d});
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        ones = ones_of({2'b00, qm[7:0]});
        zeros = 8 - ones;
        cnt_out = cnt_in;
        if (cnt_in == 0 || ones == 4) begin
            if (qm[8]) begin sym = {2'b01, qm[7:0]};  cnt_out += ones - zeros; end
            else       begin sym = {2'b10, ~qm[7:0]}; cnt_out += zeros - ones; end
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            cnt_out += 2 * int'(qm[8]) + zeros - ones;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            cnt_out += -2 * (1 - int'(qm[8])) + ones - zeros;
        end
    endtask

    task automatic model_reset();
        k = 0;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
        e_sym[0] = 10'b1010101011; e_sym[1] = 10'b1101010100; e_sym[2] = 10'b1101010100;
        for (int c = 0; c < 3; c++) e_cnt[c] = 0;
    endtask

    // Advance the reference by one clock and let the DUT take one edge.
    task automatic tick();
        logic [9:0] s;
        int c, x, y;
        for (int ch = 0; ch < 3; ch++) begin
            if (e_de) begin
                ref_encode(e_rgb[8*ch +: 8], e_cnt[ch], s, c);
                e_sym[ch] = s; e_cnt[ch] = c;
            end else begin
                e_sym[ch] = (ch == 0) ? ctrl[{e_vs, e_hs}] : ctrl[0];
                e_cnt[ch] = 0;
            end
        end
        x = k % HP; y = (k / HP) % VL;
        e_de  = (x < HA) && (y < VA);
        e_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        e_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        e_rgb = e_de ? bars[x / 80] : 24'h0;
        k++;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        tests += 9;
        if (pixel_x !== 10'd0) begin failed++; $display("FAIL reset_x got %0d want 0", pixel_x); end
        if (pixel_y !== 10'd0) begin failed++; $display("FAIL reset_y got %0d want 0", pixel_y); end
        if (de !== 1'b0) begin failed++; $display("FAIL reset_de got %b want 0", de); end
        if (hsync !== 1'b1) begin failed++; $display("FAIL reset_hsync got %b want 1", hsync); end
        if (vsync !== 1'b1) begin failed++; $display("FAIL reset_vsync got %b want 1", vsync); end
        if (tmds_ch0 !== 10'b1010101011) begin failed++; $display("FAIL reset_ch0 got %b want 1010101011", tmds_ch0); end
        if (tmds_ch1 !== 10'b1101010100) begin failed++; $display("FAIL reset_ch1 got %b want 1101010100", tmds_ch1); end
        if (tmds_ch2 !== 10'b1101010100) begin failed++; $display("FAIL reset_ch2 got %b want 1101010100", tmds_ch2); end
        if (tmds_clk !== 10'b0000011111) begin failed++; $display("FAIL reset_clk got %b want 0000011111", tmds_clk); end
        rst_in = 1'b0;
        model_reset();
    endtask

    // Runs ncyc clocks from a fresh reset (k==0) and checks every sample.
    task automatic test_free_run(input int ncyc, input string tag);
        int bad_cnt = 0, bad_sync = 0, bad_sym = 0, bad_dec = 0, bad_disp = 0, bad_clk = 0;
        int bad_hs = 0, bad_vs = 0, xw = 0, yw = 0, de_hi = 0, hs_len = 0, vs_len = 0;
        int run_disp [3] = '{0, 0, 0};
        logic prev_de, prev_hs, prev_vs;
        logic [23:0] prev_rgb;
        logic [9:0] px_prev, py_prev, sym;
        prev_de = de; prev_rgb = e_rgb; prev_hs = hsync; prev_vs = vsync;
        px_prev = pixel_x; py_prev = pixel_y;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (pixel_x !== 10'(k % HP) || pixel_y !== 10'((k / HP) % VL)) bad_cnt++;
            if ({de, hsync, vsync} !== {e_de, e_hs, e_vs}) bad_sync++;
            if (tmds_ch0 !== e_sym[0] || tmds_ch1 !== e_sym[1] || tmds_ch2 !== e_sym[2]) bad_sym++;
            if (tmds_clk !== 10'b0000011111) bad_clk++;
            if (px_prev == 10'(HP - 1) && pixel_x == 10'd0) xw++;
            if (py_prev == 10'(VL - 1) && pixel_y == 10'd0) yw++;
            if (de === 1'b1) de_hi++;
            for (int ch = 0; ch < 3; ch++) begin
                sym = (ch == 0) ? tmds_ch0 : ((ch == 1) ? tmds_ch1 : tmds_ch2);
                if (prev_de) begin
                    if (tmds_decode(sym) !== prev_rgb[8*ch +: 8]) bad_dec++;
                    run_disp[ch] += 2 * ones_of(sym) - 10;
                    if (run_disp[ch] > 10 || run_disp[ch] < -10) bad_disp++;
                end else begin
                    run_disp[ch] = 0;
                end
            end
            // Independent sync-pulse start/width checks against raw counter positions.
            if (prev_hs === 1'b1 && hsync === 1'b0 && (k % HP) != HA + HF + 1) bad_hs++;
            if (hsync === 1'b0) hs_len++;
            if (prev_hs === 1'b0 && hsync === 1'b1) begin
                if (hs_len != HS) bad_hs++;
                hs_len = 0;
            end
            if (prev_vs === 1'b1 && vsync === 1'b0 && (k % FRAME) != (VA + VF) * HP + 1) bad_vs++;
            if (vsync === 1'b0) vs_len++;
            if (prev_vs === 1'b0 && vsync === 1'b1) begin
                if (vs_len != VS * HP) bad_vs++;
                vs_len = 0;
            end
            prev_de = de; prev_rgb = e_rgb; prev_hs = hsync; prev_vs = vsync;
            px_prev = pixel_x; py_prev = pixel_y;
        end
        tests += 11;
        if (bad_cnt != 0) begin failed++; $display("FAIL %s_counters got %0d bad cycles want 0", tag, bad_cnt); end
        if (bad_sync != 0) begin failed++; $display("FAIL %s_de_sync got %0d bad cycles want 0", tag, bad_sync); end
        if (bad_sym != 0) begin failed++; $display("FAIL %s_symbols got %0d bad cycles want 0", tag, bad_sym); end
        if (bad_dec != 0) begin failed++; $display("FAIL %s_decode got %0d bad pixels want 0", tag, bad_dec); end
        if (bad_disp != 0) begin failed++; $display("FAIL %s_disparity got %0d out-of-range want 0", tag, bad_disp); end
        if (bad_clk != 0) begin failed++; $display("FAIL %s_tmds_clk got %0d bad cycles want 0", tag, bad_clk); end
        if (bad_hs != 0) begin failed++; $display("FAIL %s_hsync_pulse got %0d bad pulses want 0", tag, bad_hs); end
        if (bad_vs != 0) begin failed++; $display("FAIL %s_vsync_pulse got %0d bad pulses want 0", tag, bad_vs); end
        if (xw != ncyc / HP) begin failed++; $display("FAIL %s_x_wraps got %0d want %0d", tag, xw, ncyc / HP); end
        if (yw != ncyc / FRAME) begin failed++; $display("FAIL %s_y_wraps got %0d want %0d", tag, yw, ncyc / FRAME); end
        if (de_hi != (ncyc / FRAME) * HA * VA) begin
            failed++; $display("FAIL %s_de_count got %0d want %0d", tag, de_hi, (ncyc / FRAME) * HA * VA);
        end
    endtask

    // Known bars decoded from the symbols two clocks after their h position.
    task automatic test_pattern();
        int pts [4] = '{0, 80, 240, 560};
        logic [23:0] got;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        for (int p = 0; p < 4; p++) begin
            while (k < pts[p] + 2) tick();
            got = {tmds_decode(tmds_ch2), tmds_decode(tmds_ch1), tmds_decode(tmds_ch0)};
            tests++;
            if (got !== bars[pts[p] / 80]) begin
                failed++; $display("FAIL pattern_h%0d got %h want %h", pts[p], got, bars[pts[p] / 80]);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        while (k < 5 * HP + 300) tick();
        tests++;
        if ({pixel_y, pixel_x} !== {10'd5, 10'd300}) begin
            failed++; $display("FAIL mid_position got (%0d,%0d) want (300,5)", pixel_x, pixel_y);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        tests += 4;
        if ({pixel_x, pixel_y} !== 20'd0) begin failed++; $display("FAIL mid_counters got (%0d,%0d) want (0,0)", pixel_x, pixel_y); end
        if ({de, hsync, vsync} !== 3'b011) begin failed++; $display("FAIL mid_strobes got %b want 011", {de, hsync, vsync}); end
        if (tmds_ch0 !== 10'b1010101011) begin failed++; $display("FAIL mid_ch0 got %b want 1010101011", tmds_ch0); end
        if ({tmds_ch1, tmds_ch2} !== {10'b1101010100, 10'b1101010100}) begin
            failed++; $display("FAIL mid_ch12 got %b %b want 1101010100", tmds_ch1, tmds_ch2);
        end
        rst_in = 1'b0;
        model_reset();
        test_free_run(FRAME, "after_reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

    initial begin
        @(negedge clk_in);
        test_reset();
        test_free_run(2 * FRAME, "free_run");
        test_pattern();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
